// File: rtl/bsg_wb_burst_arbiter_if.sv
// Shared Wishbone bus bundle: N master request ports plus the single downstream slave port.
// "slave" is the arbiter's view; "master" is the view of whatever drives the masters and the slave.
interface bsg_wb_burst_arbiter_if #(
  parameter int num_masters_p = 2,
  parameter int addr_width_p  = 32,
  parameter int data_width_p  = 64
);
  localparam int sel_width_lp = data_width_p / 8;

  logic [num_masters_p-1:0]              m_cyc_i;
  logic [num_masters_p-1:0]              m_stb_i;
  logic [num_masters_p-1:0]              m_we_i;
  logic [num_masters_p*addr_width_p-1:0] m_adr_i;
  logic [num_masters_p*data_width_p-1:0] m_dat_i;
  logic [num_masters_p*sel_width_lp-1:0] m_sel_i;
  logic [num_masters_p*3-1:0]            m_cti_i;
  logic [num_masters_p*2-1:0]            m_bte_i;
  logic [num_masters_p-1:0]              m_ack_o;
  logic [data_width_p-1:0]               m_dat_o;

  logic                    s_cyc_o;
  logic                    s_stb_o;
  logic                    s_we_o;
  logic [addr_width_p-1:0] s_adr_o;
  logic [data_width_p-1:0] s_dat_o;
  logic [sel_width_lp-1:0] s_sel_o;
  logic [2:0]              s_cti_o;
  logic [1:0]              s_bte_o;
  logic                    s_ack_i;
  logic [data_width_p-1:0] s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    input  s_ack_i, s_dat_i,
    output m_ack_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    output s_ack_i, s_dat_i,
    input  m_ack_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o
  );
endinterface

// File: rtl/bsg_wb_burst_arbiter.sv
// Burst-aware round-robin Wishbone arbiter; grant held for the grantee's whole cyc (optional BSG_WB_ARB_PROTOCOL_CHECK_EN).
// Grant registers one cycle after request, slave port muxed combinationally; losing masters simply wait with cyc high.
module bsg_wb_burst_arbiter #(
  parameter int num_masters_p = 2,
  parameter int addr_width_p  = 32,
  parameter int data_width_p  = 64
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  bsg_wb_burst_arbiter_if.slave            bus,
  output logic [num_masters_p-1:0]         grant_o,
  output logic                             proto_err_o,
  output logic [$clog2(num_masters_p)-1:0] proto_err_id_o
);
  localparam int id_w_lp  = $clog2(num_masters_p);
  localparam int sel_w_lp = data_width_p / 8;

  typedef enum logic [1:0] {IDLE, OWN, BURST} state_e;

  state_e                   state_q, state_d;
  logic [num_masters_p-1:0] grant_q, grant_d;
  logic [id_w_lp-1:0]       ptr_q, ptr_d;
  logic [4:0]               cnt_q, cnt_d;

  logic [id_w_lp-1:0]      g_idx, win;
  logic                    found, owned, ack_beat, burst_cti;
  logic                    g_cyc, g_stb, g_we;
  logic [addr_width_p-1:0] g_adr;
  logic [data_width_p-1:0] g_dat;
  logic [sel_w_lp-1:0]     g_sel;
  logic [2:0]              g_cti;
  logic [1:0]              g_bte;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= id_w_lp'(num_masters_p - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grantee mux: everything on the slave port is zero while nobody holds the grant.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < num_masters_p; i++)
      if (grant_q[i]) g_idx = id_w_lp'(i);
    owned     = |grant_q;
    g_cyc     = owned & bus.m_cyc_i[g_idx];
    g_stb     = owned & bus.m_stb_i[g_idx];
    g_we      = owned & bus.m_we_i[g_idx];
    g_adr     = owned ? bus.m_adr_i[g_idx*addr_width_p +: addr_width_p] : '0;
    g_dat     = owned ? bus.m_dat_i[g_idx*data_width_p +: data_width_p] : '0;
    g_sel     = owned ? bus.m_sel_i[g_idx*sel_w_lp +: sel_w_lp] : '0;
    g_cti     = owned ? bus.m_cti_i[g_idx*3 +: 3] : '0;
    g_bte     = owned ? bus.m_bte_i[g_idx*2 +: 2] : '0;
    ack_beat  = bus.s_ack_i & g_stb;
    burst_cti = (g_cti == 3'b001) || (g_cti == 3'b010);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    found   = 1'b0;
    win     = '0;
    // Search starts one past the last winner so every requester gets a turn.
    for (int k = 1; k <= num_masters_p; k++) begin
      if (!found && bus.m_cyc_i[id_w_lp'((int'(ptr_q) + k) % num_masters_p)]) begin
        found = 1'b1;
        win   = id_w_lp'((int'(ptr_q) + k) % num_masters_p);
      end
    end
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = {{(num_masters_p-1){1'b0}}, 1'b1} << win;
          ptr_d   = win;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (ack_beat && burst_cti) begin
          state_d = BURST;
          cnt_d   = 5'd1;
        end
      end
      BURST: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (ack_beat) begin
          if (g_cti == 3'b111) begin
            state_d = OWN;
            cnt_d   = '0;
          end else if (cnt_q != 5'd31) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.s_cyc_o = g_cyc;
  assign bus.s_stb_o = g_stb;
  assign bus.s_we_o  = g_we;
  assign bus.s_adr_o = g_adr;
  assign bus.s_dat_o = g_dat;
  assign bus.s_sel_o = g_sel;
  assign bus.s_cti_o = g_cti;
  assign bus.s_bte_o = g_bte;
  assign bus.m_ack_o = {num_masters_p{bus.s_ack_i}} & grant_q;
  assign bus.m_dat_o = bus.s_dat_i;
  assign grant_o     = grant_q;

`ifdef BSG_WB_ARB_PROTOCOL_CHECK_EN
  logic [2:0]         bcti_q, bcti_d;
  logic [1:0]         bbte_q, bbte_d;
  logic               err_q, err_d, err_hit;
  logic [id_w_lp-1:0] err_id_q, err_id_d;
  logic [4:0]         wrap_lim;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bcti_q   <= '0;
      bbte_q   <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      bcti_q   <= bcti_d;
      bbte_q   <= bbte_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  // Burst type is captured on the opening beat and every later beat is held against it.
  always_comb begin
    bcti_d  = bcti_q;
    bbte_d  = bbte_q;
    err_hit = 1'b0;
    case (bbte_q)
      2'b01:   wrap_lim = 5'd4;
      2'b10:   wrap_lim = 5'd8;
      2'b11:   wrap_lim = 5'd16;
      default: wrap_lim = 5'd0;
    endcase
    if (state_q == OWN && g_cyc && ack_beat && burst_cti) begin
      bcti_d = g_cti;
      bbte_d = g_bte;
    end
    if (state_q == BURST) begin
      if (!g_cyc) begin
        err_hit = 1'b1;
      end else begin
        if (g_bte != bbte_q) err_hit = 1'b1;
        if (g_cti != bcti_q && g_cti != 3'b111) err_hit = 1'b1;
        if (ack_beat && g_cti != 3'b111 && wrap_lim != 5'd0 && cnt_q >= wrap_lim) err_hit = 1'b1;
      end
    end
    err_d    = err_q | err_hit;
    err_id_d = (err_hit && !err_q) ? g_idx : err_id_q;
  end

  assign proto_err_o    = err_q;
  assign proto_err_id_o = err_id_q;
`else
  assign proto_err_o    = 1'b0;
  assign proto_err_id_o = '0;
`endif
endmodule
